// File: rtl/nes_pad_pkg.sv
// Shared NES pad protocol definitions: FSM state encoding, button bit indices
// and the turbo masking helper used by the responder.
package nes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } pad_state_e;

    localparam int unsigned NUM_BUTTONS = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // A and B are gated off during the released half of the turbo cycle.
    function automatic logic [NUM_BUTTONS-1:0] turbo_mask(
        input logic [NUM_BUTTONS-1:0] buttons,
        input logic [1:0]             turbo,
        input logic                   phase
    );
        logic [NUM_BUTTONS-1:0] eff;
        eff        = buttons;
        eff[BTN_A] = buttons[BTN_A] & (~turbo[0] | phase);
        eff[BTN_B] = buttons[BTN_B] & (~turbo[1] | phase);
        return eff;
    endfunction

endpackage

// File: rtl/nes_pad_sync.sv
// Multi-stage synchronizer for an asynchronous host pin, followed by
// rise/fall detection on the synchronized level.
module nes_pad_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller (4021-style) emulation on the latch/clock/data pins.
// Optional turbo on A/B is compiled in with `define NES_PAD_TURBO_EN.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 27000,
    parameter int unsigned TURBO_DIV      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_latch,
    input  logic       i_data_clock,
    output logic       o_serial_data,
    input  logic [7:0] i_buttons,
    input  logic [1:0] i_turbo,
    output logic       o_frame_done,
    output logic       o_busy
);

    localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic latch_level;
    logic latch_rise;
    logic latch_fall;
    logic clk_rise;
    logic unused_clk_level;
    logic unused_clk_fall;
    logic clk_adv;

    pad_state_e      state_q,      state_d;
    logic [3:0]      idx_q,        idx_d;
    logic [TO_W-1:0] to_cnt_q,     to_cnt_d;
    logic [7:0]      snap_q,       snap_d;
    logic            serial_q,     serial_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      eff;

    nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_data_latch),
        .o_level (latch_level),
        .o_rise  (latch_rise),
        .o_fall  (latch_fall)
    );

    nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clock_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_data_clock),
        .o_level (unused_clk_level),
        .o_rise  (clk_rise),
        .o_fall  (unused_clk_fall)
    );

`ifdef NES_PAD_TURBO_EN
    localparam int unsigned FC_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            phase_q,     phase_d;

    // A frame is a latch fall that freezes a snapshot.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if ((state_q == LATCHED) && latch_fall) begin
            if (frame_cnt_q == FC_W'(TURBO_DIV - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign eff = turbo_mask(i_buttons, i_turbo, phase_q);
`else
    logic unused_turbo;
    assign unused_turbo = (^i_turbo) ^ (TURBO_DIV == 0);
    assign eff          = i_buttons;
`endif

    // Clock edges only count while the latch is synchronously low.
    assign clk_adv = clk_rise & ~latch_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            to_cnt_q     <= '0;
            snap_q       <= '0;
            serial_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            to_cnt_q     <= to_cnt_d;
            snap_q       <= snap_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        to_cnt_d = to_cnt_q;
        snap_d   = snap_q;
        if (latch_rise) begin
            state_d = LATCHED;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LATCHED: begin
                    snap_d = eff;
                    if (latch_fall) begin
                        state_d  = SHIFT;
                        idx_d    = '0;
                        to_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    if (clk_adv) begin
                        idx_d    = idx_q + 4'd1;
                        to_cnt_d = '0;
                        if (idx_q == 4'd7) begin
                            state_d = DONE;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d  = IDLE;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output is registered from next-state values so it settles with the state.
    always_comb begin
        serial_d     = 1'b1;
        frame_done_d = (state_q == SHIFT) && (state_d == DONE);
        case (state_d)
            IDLE:    serial_d = 1'b1;
            LATCHED: serial_d = ~eff[BTN_A];
            SHIFT:   serial_d = ~snap_d[idx_d[2:0]];
            DONE:    serial_d = 1'b0;
            default: serial_d = 1'b1;
        endcase
    end

    assign o_serial_data = serial_q;
    assign o_frame_done  = frame_done_q;
    assign o_busy        = (state_q == LATCHED) || (state_q == SHIFT);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: expected line values are queued as
// stimulus is issued and popped when the line is sampled.
module tb_nes_pad_responder;
    import nes_pad_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 200;
    localparam int unsigned TDIV = 2;
    localparam int unsigned HOLD = SYNC + 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_data_latch;
    logic       i_data_clock;
    logic       o_serial_data;
    logic [7:0] i_buttons;
    logic [1:0] i_turbo;
    logic       o_frame_done;
    logic       o_busy;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic exp_q[$];

    nes_pad_responder #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .TURBO_DIV      (TDIV)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_data_latch  (i_data_latch),
        .i_data_clock  (i_data_clock),
        .o_serial_data (o_serial_data),
        .i_buttons     (i_buttons),
        .i_turbo       (i_turbo),
        .o_frame_done  (o_frame_done),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frame_done === 1'b1) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pin_latch(input logic v);
        i_data_latch = v;
        cyc(HOLD);
    endtask

    task automatic pin_clock(input logic v);
        i_data_clock = v;
        cyc(HOLD);
    endtask

    // Real pad: active-low bits 0..7, then the line reads 0.
    task automatic push_frame(input logic [7:0] btns, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (k < 8) exp_q.push_back(~btns[k]);
            else       exp_q.push_back(1'b0);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_data_latch = 1'b0;
        i_data_clock = 1'b0;
        i_buttons = 8'h00;
        i_turbo = 2'b00;
        cyc(3);
        checks++;
        if (o_serial_data !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", o_serial_data); end
        checks++;
        if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_frame_done); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        i_rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic_read;
        int   d0;
        logic e;
        i_buttons = 8'h09;
        d0 = done_cnt;
        push_frame(i_buttons, 9);
        pin_latch(1'b1);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", o_busy); end
        pin_latch(1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) begin pin_clock(1'b1); pin_clock(1'b0); end
            e = exp_q.pop_front();
            checks++;
            if (o_serial_data !== e) begin errors++; $display("FAIL basic_bit%0d: got %b expected %b", k, o_serial_data, e); end
        end
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", o_busy); end
    endtask

    task automatic test_latched_tracking;
        logic e;
        i_buttons = 8'h00;
        exp_q.push_back(1'b1);
        pin_latch(1'b1);
        e = exp_q.pop_front();
        checks++;
        if (o_serial_data !== e) begin errors++; $display("FAIL track_before: got %b expected %b", o_serial_data, e); end
        i_buttons[BTN_A] = 1'b1;
        exp_q.push_back(1'b0);
        cyc(SYNC + 1);
        e = exp_q.pop_front();
        checks++;
        if (o_serial_data !== e) begin errors++; $display("FAIL track_after: got %b expected %b", o_serial_data, e); end
        i_buttons[BTN_A] = 1'b0;
        exp_q.push_back(1'b1);
        cyc(SYNC + 1);
        e = exp_q.pop_front();
        checks++;
        if (o_serial_data !== e) begin errors++; $display("FAIL track_release: got %b expected %b", o_serial_data, e); end
        pin_latch(1'b0);
    endtask

    task automatic test_abort_relatch;
        int   d0;
        logic e;
        i_buttons = 8'hA5;
        pin_latch(1'b1);
        pin_latch(1'b0);
        for (int k = 0; k < 3; k++) begin pin_clock(1'b1); pin_clock(1'b0); end
        d0 = done_cnt;
        i_buttons = 8'h3C;
        push_frame(i_buttons, 9);
        pin_latch(1'b1);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL abort_nodone: got %0d pulses expected 0", done_cnt - d0); end
        pin_latch(1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) begin pin_clock(1'b1); pin_clock(1'b0); end
            e = exp_q.pop_front();
            checks++;
            if (o_serial_data !== e) begin errors++; $display("FAIL abort_bit%0d: got %b expected %b", k, o_serial_data, e); end
        end
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL abort_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int d0;
        i_buttons = 8'hFF;
        pin_latch(1'b1);
        pin_latch(1'b0);
        for (int k = 0; k < 2; k++) begin pin_clock(1'b1); pin_clock(1'b0); end
        d0 = done_cnt;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before: got %b expected 1", o_busy); end
        cyc(TMO + 5);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", o_busy); end
        checks++;
        if (o_serial_data !== 1'b1) begin errors++; $display("FAIL timeout_serial: got %b expected 1", o_serial_data); end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL timeout_nodone: got %0d pulses expected 0", done_cnt - d0); end
    endtask

    task automatic test_overclock;
        int   d0;
        logic e;
        i_buttons = 8'h5A;
        d0 = done_cnt;
        push_frame(i_buttons, 11);
        pin_latch(1'b1);
        pin_latch(1'b0);
        for (int k = 0; k < 11; k++) begin
            if (k != 0) begin pin_clock(1'b1); pin_clock(1'b0); end
            e = exp_q.pop_front();
            checks++;
            if (o_serial_data !== e) begin errors++; $display("FAIL over_bit%0d: got %b expected %b", k, o_serial_data, e); end
        end
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL over_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_latch_clock_same;
        int   d0;
        logic e;
        i_buttons = 8'hC3;
        pin_latch(1'b1);
        pin_latch(1'b0);
        for (int k = 0; k < 2; k++) begin pin_clock(1'b1); pin_clock(1'b0); end
        i_buttons = 8'h66;
        d0 = done_cnt;
        exp_q.push_back(~i_buttons[BTN_A]);
        i_data_latch = 1'b1;
        i_data_clock = 1'b1;
        cyc(HOLD);
        e = exp_q.pop_front();
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b expected 1", o_busy); end
        checks++;
        if (o_serial_data !== e) begin errors++; $display("FAIL same_serial: got %b expected %b", o_serial_data, e); end
        pin_clock(1'b0);
        pin_clock(1'b1);
        pin_clock(1'b0);
        push_frame(i_buttons, 9);
        pin_latch(1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) begin pin_clock(1'b1); pin_clock(1'b0); end
            e = exp_q.pop_front();
            checks++;
            if (o_serial_data !== e) begin errors++; $display("FAIL same_bit%0d: got %b expected %b", k, o_serial_data, e); end
        end
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL same_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_read;
        i_buttons = 8'h00;
        pin_latch(1'b1);
        pin_latch(1'b0);
        for (int k = 0; k < 2; k++) begin pin_clock(1'b1); pin_clock(1'b0); end
        i_rst = 1'b1;
        cyc(1);
        i_rst = 1'b0;
        checks++;
        if (o_serial_data !== 1'b1) begin errors++; $display("FAIL midrst_serial: got %b expected 1", o_serial_data); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
        cyc(2);
    endtask

    task automatic test_turbo;
        logic phase;
        int   fcnt;
        logic a;
        logic e;
        i_rst = 1'b1;
        cyc(2);
        i_rst = 1'b0;
        cyc(2);
        i_buttons = 8'h01;
        i_turbo = 2'b01;
        phase = 1'b0;
        fcnt = 0;
        for (int f = 0; f < 6; f++) begin
`ifdef NES_PAD_TURBO_EN
            a = i_buttons[BTN_A] & (~i_turbo[0] | phase);
`else
            a = i_buttons[BTN_A];
`endif
            exp_q.push_back(~a);
            pin_latch(1'b1);
            pin_latch(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (o_serial_data !== e) begin errors++; $display("FAIL turbo_frame%0d: got %b expected %b", f, o_serial_data, e); end
            fcnt++;
            if (fcnt == TDIV) begin fcnt = 0; phase = ~phase; end
        end
        i_turbo = 2'b00;
    endtask

    initial begin
        test_reset;
        test_basic_read;
        test_latched_tracking;
        test_abort_relatch;
        test_timeout;
        test_overclock;
        test_latch_clock_same;
        test_reset_mid_read;
        test_turbo;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Device-side end of the NES serial gamepad protocol: emulates a standard NES controller (4021 shift register) on the latch/clock/data wires. It is driven by a console or by our gamepad reader block. Takes an 8-bit button vector from the core, such as a USB/BT pad bridge or a test pattern source. Samples the asynchronous latch and clock pins, and shifts buttons out active-low in A, B, Select, Start, Up, Down, Left, Right order.

## Interface
- SYNC_STAGES, 2: flip-flop stages on each async input pin (min 2).
- TIMEOUT_CYCLES, 27000: i_clk cycles without a clock edge before an in-progress read is abandoned (1 ms at 27 MHz).
- TURBO_DIV, 4: latch frames per turbo phase toggle (only used with turbo compiled in).
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_data_latch  in  1  latch pin from host, async, active-high.
- i_data_clock  in  1  clock pin from host, async, rising edge advances the bit.
- o_serial_data  out  1  data pin to host, active-low (0 = pressed).
- i_buttons  in  8  button state, active-high; bit0 A … bit7 Right.
- i_turbo  in  2  turbo request, bit0 A, bit1 B (ignored without turbo).
- o_frame_done  out  1  one-cycle pulse when the 8th bit has been clocked out.
- o_busy  out  1  high in LATCHED or SHIFT.

## Operation
- Latch and clock each pass through a SYNC_STAGES synchronizer, then a rising/falling edge detector on the synchronized level.
- State machine, states IDLE, LATCHED, SHIFT, DONE:
  - IDLE: o_serial_data=1. Latch rise → LATCHED.
  - LATCHED: shift register reloads effective buttons every cycle (4021 parallel mode). o_serial_data = ~eff[0], tracking live input. Clock edges are ignored. Latch fall → freeze snapshot, bit index=0, → SHIFT.
  - SHIFT: o_serial_data = ~snap[idx]. Clock rise → idx+1. When idx reaches 8: pulse o_frame_done, → DONE. No clock rise for TIMEOUT_CYCLES → IDLE, no o_frame_done.
  - DONE: o_serial_data=0, matching the official controller, which reads as 1 after 8 bits. Further clock rises are harmless. Latch rise → LATCHED.
- A latch rise in any state, including mid-SHIFT, aborts and goes to LATCHED; no o_frame_done.
- A latch rise and a clock rise in the same cycle: latch wins.
- A clock rise while latch is synchronously high is ignored.
- Bit index is 4 bits, saturating at 8. Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it clears on every clock rise and on entry to SHIFT.

## Timing
- Reset values: o_serial_data=1, o_frame_done=0, o_busy=0. State IDLE, idx=0, counters 0, turbo phase 0.
- Pin-to-output latency is SYNC_STAGES+1 i_clk cycles, from a latch fall or clock rise at the pin to the new o_serial_data. o_serial_data is registered.
- The host must hold each clock/latch level for at least SYNC_STAGES+2 i_clk cycles. Shorter pulses may be missed; this is not detected.
- o_frame_done is asserted in the cycle DONE is entered.
- Reset mid-read returns to IDLE on the next edge. The line goes to 1 the cycle after reset is sampled.

## Configuration
- NES_PAD_TURBO_EN defined:
  - A frame counter counts latch falls; turbo phase toggles every TURBO_DIV frames.
  - eff[0] = i_buttons[0] & (~i_turbo[0] | phase); eff[1] is the same using i_turbo[1].
  - Other bits are passed through.
- NES_PAD_TURBO_EN undefined: eff = i_buttons. i_turbo is left unconnected internally, and no frame counter is built.

## Structure
- nes_pad_pkg: state enum (IDLE, LATCHED, SHIFT, DONE) and button index constants BTN_A=0 … BTN_RIGHT=7, shared with the reader side.
- Sub-module nes_pad_sync: SYNC_STAGES synchronizer with o_level, o_rise, o_fall. Instantiated twice, once for latch and once for clock.

## Test plan
- i_buttons=8'h09 (A+Start); 12 µs latch then 8 clock pulses → sampled line 0,1,1,0,1,1,1,1; one o_frame_done pulse.
- Latch high while i_buttons bit0 toggles 0→1 → o_serial_data follows 1→0 within SYNC_STAGES+1 cycles.
- Latch, 3 clocks, then re-latch → no o_frame_done; next 8 clocks deliver the new snapshot from bit A.
- Latch, 2 clocks, then stall TIMEOUT_CYCLES+5 → o_busy=0, o_serial_data=1, no o_frame_done.
- 10 clocks after latch → bits 9 and 10 read 0; o_frame_done exactly once; same-cycle latch+clock rise → LATCHED.
- With NES_PAD_TURBO_EN, TURBO_DIV=2, i_buttons=8'h01, i_turbo=2'b01 → A alternates pressed/released every 2 frames; without the macro, A is pressed every frame.
